// File: rtl/xillybus_wrapper_sdiv_pkg.sv
// rtl/xillybus_wrapper_sdiv_pkg.sv - shared widths, state encoding and saturation limits for the divider
package xillybus_wrapper_sdiv_pkg;

    localparam int DIVIDEND_W = 30;
    localparam int DIVISOR_W  = 15;
    localparam int QUOT_W     = 15;
    localparam int REM_W      = 16;
    localparam int CNT_W      = 5;

    localparam int QMAX = 16383;
    localparam int QMIN = -16384;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/xillybus_wrapper_sdiv_step.sv
// rtl/xillybus_wrapper_sdiv_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract
module xillybus_wrapper_sdiv_step #(
    parameter int REM_W     = 16,
    parameter int DIVISOR_W = 15
) (
    input  logic [REM_W-1:0]     prem_in,
    input  logic                 din_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [REM_W-1:0]     prem_out,
    output logic                 q_bit
);

    localparam int SW = REM_W + 1;

    logic [SW-1:0] shifted;
    logic [SW-1:0] diff;

    // Trial subtract; the borrow out of the widened difference decides the quotient bit
    always_comb begin
        shifted  = {prem_in, din_bit};
        diff     = shifted - SW'(divisor);
        q_bit    = ~diff[SW-1];
        prem_out = q_bit ? diff[REM_W-1:0] : shifted[REM_W-1:0];
    end

endmodule

// File: rtl/xillybus_wrapper_sdiv.sv
// rtl/xillybus_wrapper_sdiv.sv - multi-cycle signed-by-unsigned restoring divider with ap_* handshake
module xillybus_wrapper_sdiv #(
    parameter int DIVIDEND_W = xillybus_wrapper_sdiv_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = xillybus_wrapper_sdiv_pkg::DIVISOR_W,
    parameter int QUOT_W     = xillybus_wrapper_sdiv_pkg::QUOT_W,
    parameter int REM_W      = xillybus_wrapper_sdiv_pkg::REM_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic [QUOT_W-1:0]     dout,
    output logic [REM_W-1:0]      rem,
    output logic                  ovf,
    output logic                  dz
);

    import xillybus_wrapper_sdiv_pkg::*;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    // Dividend magnitude; quotient bits shift in at the bottom as dividend bits leave the top
    logic [DIVIDEND_W-1:0]   mag_q, mag_d;
    logic [REM_W-1:0]        prem_q, prem_d;
    logic [DIVISOR_W-1:0]    div_q, div_d;
    logic                    sign_q, sign_d;
    logic                    dzf_q, dzf_d;
    logic [QUOT_W-1:0]       dout_q, dout_d;
    logic [REM_W-1:0]        rem_q, rem_d;
    logic                    ovf_q, ovf_d;
    logic                    dz_q, dz_d;
    logic                    ap_done_q, ap_done_d;

    logic [REM_W-1:0]        step_prem;
    logic                    step_q;

    xillybus_wrapper_sdiv_step #(
        .REM_W     (REM_W),
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .prem_in  (prem_q),
        .din_bit  (mag_q[DIVIDEND_W-1]),
        .divisor  (div_q),
        .prem_out (step_prem),
        .q_bit    (step_q)
    );

    assign ap_idle  = (state_q == S_IDLE);
    assign ap_ready = ap_start && (state_q == S_IDLE);
    assign ap_done  = ap_done_q;
    assign dout     = dout_q;
    assign rem      = rem_q;
    assign ovf      = ovf_q;
    assign dz       = dz_q;

    // Next-state and datapath: capture, iterate, sign-fix/saturate, then signal completion
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        prem_d    = prem_q;
        div_d     = div_q;
        sign_d    = sign_q;
        dzf_d     = dzf_q;
        dout_d    = dout_q;
        rem_d     = rem_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        ap_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    mag_d   = din0[DIVIDEND_W-1] ? -din0 : din0;
                    sign_d  = din0[DIVIDEND_W-1];
                    div_d   = din1;
                    prem_d  = '0;
                    cnt_d   = '0;
                    dzf_d   = (din1 == '0);
                    state_d = (din1 == '0) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                prem_d = step_prem;
                mag_d  = {mag_q[DIVIDEND_W-2:0], step_q};
                if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                dz_d    = dzf_q;
                if (dzf_q) begin
                    dout_d = sign_q ? QUOT_W'(QMIN) : QUOT_W'(QMAX);
                    rem_d  = '0;
                    ovf_d  = 1'b0;
                end else begin
                    rem_d = sign_q ? -prem_q : prem_q;
                    if (sign_q) begin
                        ovf_d  = (mag_q > DIVIDEND_W'(-QMIN));
                        dout_d = ovf_d ? QUOT_W'(QMIN) : -mag_q[QUOT_W-1:0];
                    end else begin
                        ovf_d  = (mag_q > DIVIDEND_W'(QMAX));
                        dout_d = ovf_d ? QUOT_W'(QMAX) : mag_q[QUOT_W-1:0];
                    end
                end
            end
            S_DONE: begin
                ap_done_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous active-high reset
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mag_q     <= '0;
            prem_q    <= '0;
            div_q     <= '0;
            sign_q    <= 1'b0;
            dzf_q     <= 1'b0;
            dout_q    <= '0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
            ap_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            prem_q    <= prem_d;
            div_q     <= div_d;
            sign_q    <= sign_d;
            dzf_q     <= dzf_d;
            dout_q    <= dout_d;
            rem_q     <= rem_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
            ap_done_q <= ap_done_d;
        end
    end

endmodule

// File: tb/tb_xillybus_wrapper_sdiv.sv
// tb/tb_xillybus_wrapper_sdiv.sv - directed vector table plus handshake/reset sequences for the divider
module tb_xillybus_wrapper_sdiv;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic [29:0] din0;
    logic [14:0] din1;
    logic [14:0] dout;
    logic [15:0] rem;
    logic        ovf;
    logic        dz;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [29:0] a;
        logic [14:0] b;
        int          q;
        int          r;
        int          ovf;
        int          dz;
        int          lat;
    } vec_t;

    vec_t tbl[16];

    xillybus_wrapper_sdiv dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .dout     (dout),
        .rem      (rem),
        .ovf      (ovf),
        .dz       (dz)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [29:0] a, input logic [14:0] b, output int lat);
        din0     = a;
        din1     = b;
        ap_start = 1'b1;
        #1;
        chk("ready_before_accept", longint'(ap_ready), 1);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        chk("idle_after_accept", longint'(ap_idle), 0);
        lat = 0;
        while (!ap_done && lat < 100) begin
            @(posedge ap_clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int     lat;
        int     readies;
        int     dones;
        int     second_ready;
        logic [29:0] ra;
        logic [14:0] rb;
        longint la, lb, eq, er, eovf;

        tbl[0]  = '{30'(-5332114),    15'd1234,  -4321,      0, 0, 0, 32};
        tbl[1]  = '{30'(-7),          15'd2,     -3,        -1, 0, 0, 32};
        tbl[2]  = '{30'(7),           15'd2,      3,         1, 0, 0, 32};
        tbl[3]  = '{30'(536870911),   15'd1,      16383,     0, 1, 0, 32};
        tbl[4]  = '{30'(-536870912),  15'd1,     -16384,     0, 1, 0, 32};
        tbl[5]  = '{30'(-16384),      15'd1,     -16384,     0, 0, 0, 32};
        tbl[6]  = '{30'(100),         15'd0,      16383,     0, 0, 1, 2};
        tbl[7]  = '{30'(-100),        15'd0,     -16384,     0, 0, 1, 2};
        tbl[8]  = '{30'(16383),       15'd1,      16383,     0, 0, 0, 32};
        tbl[9]  = '{30'(16384),       15'd1,      16383,     0, 1, 0, 32};
        tbl[10] = '{30'(-16385),      15'd1,     -16384,     0, 1, 0, 32};
        tbl[11] = '{30'(1000000),     15'd32767,  30,    16990, 0, 0, 32};
        tbl[12] = '{30'(-1000000),    15'd32767, -30,   -16990, 0, 0, 32};
        tbl[13] = '{30'(5),           15'd7,      0,         5, 0, 0, 32};
        tbl[14] = '{30'(-5),          15'd7,      0,        -5, 0, 0, 32};
        tbl[15] = '{30'(536870911),   15'd32767,  16383, 16383, 1, 0, 32};

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_idle", longint'(ap_idle), 1);
        chk("rst_done", longint'(ap_done), 0);
        chk("rst_dout", longint'($signed(dout)), 0);
        chk("rst_rem",  longint'($signed(rem)), 0);
        chk("rst_ovf",  longint'(ovf), 0);
        chk("rst_dz",   longint'(dz), 0);
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].a, tbl[i].b, lat);
            chk($sformatf("v%0d_lat", i),  longint'(lat), longint'(tbl[i].lat));
            chk($sformatf("v%0d_dout", i), longint'($signed(dout)), longint'(tbl[i].q));
            chk($sformatf("v%0d_rem", i),  longint'($signed(rem)), longint'(tbl[i].r));
            chk($sformatf("v%0d_ovf", i),  longint'(ovf), longint'(tbl[i].ovf));
            chk($sformatf("v%0d_dz", i),   longint'(dz), longint'(tbl[i].dz));
            @(posedge ap_clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), longint'(ap_done), 0);
        end

        din0         = 30'(-7);
        din1         = 15'd2;
        ap_start     = 1'b1;
        readies      = 0;
        dones        = 0;
        second_ready = -1;
        for (int i = 0; i < 66; i++) begin
            #1;
            if (ap_ready) begin
                readies++;
                if (i > 0 && second_ready < 0) second_ready = i;
            end
            if (ap_done) dones++;
            @(posedge ap_clk);
        end
        #1;
        ap_start = 1'b0;
        chk("hold_readies", longint'(readies), 2);
        chk("hold_second_accept", longint'(second_ready), 33);
        chk("hold_dones", longint'(dones), 1);
        chk("hold_done2", longint'(ap_done), 1);
        chk("hold_dout", longint'($signed(dout)), -3);
        chk("hold_rem", longint'($signed(rem)), -1);

        din0     = 30'd1000;
        din1     = 15'd3;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (10) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("abort_idle", longint'(ap_idle), 1);
        chk("abort_dout", longint'($signed(dout)), 0);
        chk("abort_rem",  longint'($signed(rem)), 0);
        chk("abort_ovf",  longint'(ovf), 0);
        chk("abort_dz",   longint'(dz), 0);
        chk("abort_done", longint'(ap_done), 0);
        ap_rst = 1'b0;
        dones  = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ap_clk);
            #1;
            if (ap_done) dones++;
        end
        chk("abort_no_done", longint'(dones), 0);
        run_op(30'd7, 15'd2, lat);
        chk("fresh_lat",  longint'(lat), 32);
        chk("fresh_dout", longint'($signed(dout)), 3);
        chk("fresh_rem",  longint'($signed(rem)), 1);

        for (int i = 0; i < 150; i++) begin
            ra = 30'($urandom);
            ra = 30'($signed(ra) >>> $urandom_range(0, 29));
            case ($urandom_range(0, 4))
                0:       rb = 15'd32767;
                1:       rb = 15'd0;
                2:       rb = 15'($urandom_range(1, 100));
                default: rb = 15'($urandom_range(1, 32767));
            endcase
            la = longint'($signed(ra));
            lb = longint'(rb);
            if (lb == 0) begin
                eq   = (la < 0) ? -16384 : 16383;
                er   = 0;
                eovf = 0;
            end else begin
                eq   = la / lb;
                er   = la % lb;
                eovf = 0;
                if (eq > 16383) begin eq = 16383; eovf = 1; end
                if (eq < -16384) begin eq = -16384; eovf = 1; end
            end
            run_op(ra, rb, lat);
            chk($sformatf("r%0d_lat a=%0d b=%0d", i, la, lb), longint'(lat), (lb == 0) ? 2 : 32);
            chk($sformatf("r%0d_dout a=%0d b=%0d", i, la, lb), longint'($signed(dout)), eq);
            chk($sformatf("r%0d_rem a=%0d b=%0d", i, la, lb), longint'($signed(rem)), er);
            chk($sformatf("r%0d_ovf a=%0d b=%0d", i, la, lb), longint'(ovf), eovf);
            chk($sformatf("r%0d_dz a=%0d b=%0d", i, la, lb), longint'(dz), (lb == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
